// File: rtl/rx_buf_ctrl_if.sv
// Receive-buffer controller bus: byte stream in, RX memory write port, CPU-side slot status.
interface rx_buf_ctrl_if #(
  parameter int ADDR_W    = 11,
  parameter int SLOT_LOG2 = 1
);
  logic                      rx_data_v;
  logic [7:0]                rx_data;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [7:0]                mem_din;
  logic                      rel;
  logic [SLOT_LOG2-1:0]      rd_slot;
  logic [ADDR_W-SLOT_LOG2:0] rd_len;
  logic                      rd_trunc;
  logic [SLOT_LOG2:0]        ready_cnt;
  logic                      rx_irq;
  logic [15:0]               drop_cnt;

  modport master (
    output rx_data_v, rx_data, rel,
    input  mem_we, mem_addr, mem_din, rd_slot, rd_len, rd_trunc, ready_cnt, rx_irq, drop_cnt
  );

  modport slave (
    input  rx_data_v, rx_data, rel,
    output mem_we, mem_addr, mem_din, rd_slot, rd_len, rd_trunc, ready_cnt, rx_irq, drop_cnt
  );
endinterface

// File: rtl/rx_buf_ctrl.sv
// RX frame-buffer ring controller: writes frames into fixed-size slots and tracks ready slots.
// Optional macro RX_BUF_DROP_CNT_EN enables the saturating dropped-frame counter.
module rx_buf_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int SLOT_LOG2 = 1
) (
  input  logic         RX_CLK,
  input  logic         rst,
  rx_buf_ctrl_if.slave bus
);
  localparam int OFF_W = ADDR_W - SLOT_LOG2;
  localparam int CNT_W = OFF_W + 1;
  localparam int NSLOT = 1 << SLOT_LOG2;
  localparam logic [CNT_W-1:0]     SB   = CNT_W'(1) << OFF_W;
  localparam logic [SLOT_LOG2:0]   FULL = (SLOT_LOG2 + 1)'(NSLOT);

  typedef enum logic [1:0] {IDLE, WRITE, SKIP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SLOT_LOG2-1:0]   r_wr_slot, r_rd_slot;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_trunc, w_trunc_nxt;
  logic [CNT_W-1:0]       r_desc_len [NSLOT];
  logic [NSLOT-1:0]       r_desc_trunc;
  logic [SLOT_LOG2:0]     r_ready_cnt, w_ready_nxt;
  logic                   r_irq;
  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [7:0]             r_mem_din;
  logic                   w_we, w_commit, w_rel_ok, w_full;
  logic [ADDR_W-1:0]      w_addr;

  assign w_full   = (r_ready_cnt == FULL);
  assign w_rel_ok = bus.rel && (r_ready_cnt != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trunc_nxt = r_trunc;
    w_we        = 1'b0;
    w_addr      = {r_wr_slot, {OFF_W{1'b0}}};
    w_commit    = 1'b0;
    case (r_state)
      SKIP: begin
        if (!bus.rx_data_v) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (bus.rx_data_v) begin
          if (!w_full) begin
            w_we        = 1'b1;
            w_cnt_nxt   = CNT_W'(1);
            w_trunc_nxt = 1'b0;
            w_state_nxt = WRITE;
          end else begin
            w_state_nxt = SKIP;
          end
        end
      end
      WRITE: begin
        if (bus.rx_data_v) begin
          // bytes past the slot size are counted only as truncation
          if (r_cnt < SB) begin
            w_we      = 1'b1;
            w_addr    = {r_wr_slot, r_cnt[OFF_W-1:0]};
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_trunc_nxt = 1'b1;
          end
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = SKIP;
    endcase
  end

  always_comb begin
    w_ready_nxt = r_ready_cnt;
    if (w_commit && !w_rel_ok)
      w_ready_nxt = r_ready_cnt + (SLOT_LOG2 + 1)'(1);
    else if (!w_commit && w_rel_ok)
      w_ready_nxt = r_ready_cnt - (SLOT_LOG2 + 1)'(1);
  end

  // reset lands in SKIP so a frame already on the wire is ignored
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      r_state     <= SKIP;
      r_cnt       <= '0;
      r_trunc     <= 1'b0;
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_ready_cnt <= '0;
      r_irq       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_trunc     <= w_trunc_nxt;
      r_mem_we    <= w_we;
      r_ready_cnt <= w_ready_nxt;
      r_irq       <= (w_ready_nxt != '0);
      if (w_we) begin
        r_mem_addr <= w_addr;
        r_mem_din  <= bus.rx_data;
      end
      if (w_commit) r_wr_slot <= r_wr_slot + SLOT_LOG2'(1);
      if (w_rel_ok) r_rd_slot <= r_rd_slot + SLOT_LOG2'(1);
    end
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) r_desc_len[i] <= '0;
      r_desc_trunc <= '0;
    end else if (w_commit) begin
      r_desc_len[r_wr_slot]   <= r_cnt;
      r_desc_trunc[r_wr_slot] <= r_trunc;
    end
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;
  assign bus.rd_slot   = r_rd_slot;
  assign bus.rd_len    = r_desc_len[r_rd_slot];
  assign bus.rd_trunc  = r_desc_trunc[r_rd_slot];
  assign bus.ready_cnt = r_ready_cnt;
  assign bus.rx_irq    = r_irq;

`ifdef RX_BUF_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = (r_state == IDLE) && bus.rx_data_v && w_full;

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst)
      r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.drop_cnt = 16'h0000;
`endif
endmodule

// File: doc/rx_buf_ctrl.md
# rx_buf_ctrl

Receive frame-buffer controller between the offload-selected receive byte stream and the RX packet memory. Splits the RX memory into a ring of fixed-size slots and writes each incoming frame into the next free slot. Keeps a per-slot length/truncation descriptor, raises an interrupt while any frame is waiting for the CPU, and drops whole frames when the ring is full. Runs entirely in the RX_CLK domain; the CPU-side release pulse arrives already synchronised.

## Interface
- ADDR_W, 11, RX memory byte-address width.
- SLOT_LOG2, 1, log2 of slot count. NSLOT = 2^SLOT_LOG2. Slot size SB = 2^(ADDR_W-SLOT_LOG2) bytes.
- RX_CLK  in  1  receive clock, sole clock of the block.
- rst  in  1  reset, asynchronous, active-high.
- rx_data_v  in  1  byte-valid; high for the whole frame, low for at least 1 cycle between frames.
- rx_data  in  8  frame byte, valid when rx_data_v=1.
- mem_we  out  1  RX memory write strobe.
- mem_addr  out  ADDR_W  RX memory write address.
- mem_din  out  8  RX memory write data.
- rel  in  1  one-cycle pulse: CPU has consumed the oldest ready slot.
- rd_slot  out  SLOT_LOG2  index of the oldest ready slot.
- rd_len  out  ADDR_W-SLOT_LOG2+1  stored byte count of rd_slot.
- rd_trunc  out  1  rd_slot frame exceeded SB bytes.
- ready_cnt  out  SLOT_LOG2+1  number of ready slots, 0..NSLOT.
- rx_irq  out  1  high while ready_cnt != 0.
- drop_cnt  out  16  frames dropped because the ring was full; saturates at 0xFFFF.

## Operation
- State register: IDLE, WRITE, SKIP. Reset state is SKIP, so a frame already in progress when reset is released is ignored.
- SKIP: when rx_data_v=0, go to IDLE. No writes occur in SKIP.
- IDLE, rx_data_v=1, ready_cnt<NSLOT:
  - write byte to {wr_slot, 0};
  - byte count becomes 1, trunc flag is cleared;
  - go to WRITE.
- IDLE, rx_data_v=1, ready_cnt==NSLOT:
  - drop_cnt increments, saturating;
  - go to SKIP.
- WRITE, rx_data_v=1:
  - if count<SB, write byte to {wr_slot, count[ADDR_W-SLOT_LOG2-1:0]} and increment count;
  - otherwise set the trunc flag, with no write and no count change.
- WRITE, rx_data_v=0 (commit):
  - descriptor[wr_slot] takes len=count and trunc;
  - wr_slot increments modulo NSLOT;
  - ready_cnt increments;
  - go to IDLE.
- rel with ready_cnt>0: rd_slot increments modulo NSLOT and ready_cnt decrements. rel with ready_cnt==0 is ignored. The decision uses the pre-edge ready_cnt.
- Commit and accepted rel on the same edge: ready_cnt is unchanged; wr_slot and rd_slot both advance.
- rd_len and rd_trunc come from the descriptor registers indexed by rd_slot.
- rx_irq is registered: it equals (next ready_cnt != 0).
- Reset, including mid-frame:
  - all outputs are 0, and wr_slot, rd_slot and the descriptors are 0;
  - a partial frame is discarded and not counted in drop_cnt.

## Timing
- mem_we, mem_addr and mem_din are registered: a byte sampled at edge N is presented after edge N, so the write lands at edge N+1. Latency is 1 cycle.
- mem_we is deasserted in every cycle without a write. mem_addr and mem_din hold their last value.
- ready_cnt, rd_slot, rd_len and rx_irq update on the edge that samples the first rx_data_v=0 of a frame.
- A new frame may start in the cycle after commit; IDLE sees the updated ready_cnt.
- rel is single-cycle. Each high cycle counts as one release.

## Configuration
- RX_BUF_DROP_CNT_EN defined: the 16-bit saturating drop_cnt register is present as described.
- RX_BUF_DROP_CNT_EN undefined: no counter logic; drop_cnt is tied to 16'h0000. Drop behaviour is otherwise identical.

## Test plan
All scenarios use default parameters: 2 slots, SB=1024.
- After reset, rx_data_v low, then a 64-byte frame -> 64 writes at 0x000–0x03F with data matching input, one cycle delayed; then rd_slot=0, rd_len=64, rd_trunc=0, ready_cnt=1, rx_irq=1.
- Then a 100-byte frame followed by a 60-byte frame -> writes at 0x400–0x463; ready_cnt=2; the 60-byte frame produces no mem_we; drop_cnt=1 (0 without RX_BUF_DROP_CNT_EN).
- Three rel pulses -> after the first, rd_slot=1, rd_len=100, ready_cnt=1; after the second, ready_cnt=0 and rx_irq=0; the third is ignored, ready_cnt stays 0.
- 1500-byte frame into slot 0 -> exactly 1024 writes at 0x000–0x3FF; rd_len=1024, rd_trunc=1.
- rst pulsed mid-frame with rx_data_v still high after release -> no mem_we until rx_data_v falls; the next frame is written from address 0x000; drop_cnt=0.
- With ready_cnt=1, rel asserted on the commit edge of a frame into slot 1 -> ready_cnt stays 1, rd_slot=1, rx_irq remains 1.
